// File: rtl/tx_ip_pkg.sv
// Shared definitions for the IPv4 transmit path.
//   tx_state_t   : header-inserter FSM encoding
//   IPV4_HDR_LEN : fixed header length (no options)
//   IP_VER_IHL   : version 4, IHL 5
//   HB_*         : byte index of each header field in network order
package tx_ip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HEADER,
    DATA,
    DRAIN
  } tx_state_t;

  localparam int          IPV4_HDR_LEN = 20;
  localparam logic [7:0]  IP_VER_IHL   = 8'h45;

  localparam logic [4:0]  HB_VER_IHL = 5'd0;
  localparam logic [4:0]  HB_TOS     = 5'd1;
  localparam logic [4:0]  HB_LEN_HI  = 5'd2;
  localparam logic [4:0]  HB_LEN_LO  = 5'd3;
  localparam logic [4:0]  HB_ID_HI   = 5'd4;
  localparam logic [4:0]  HB_ID_LO   = 5'd5;
  localparam logic [4:0]  HB_FLAGS   = 5'd6;
  localparam logic [4:0]  HB_FRAG    = 5'd7;
  localparam logic [4:0]  HB_TTL     = 5'd8;
  localparam logic [4:0]  HB_PROTO   = 5'd9;
  localparam logic [4:0]  HB_CS_HI   = 5'd10;
  localparam logic [4:0]  HB_CS_LO   = 5'd11;
  localparam logic [4:0]  HB_SRC0    = 5'd12;
  localparam logic [4:0]  HB_SRC1    = 5'd13;
  localparam logic [4:0]  HB_SRC2    = 5'd14;
  localparam logic [4:0]  HB_SRC3    = 5'd15;
  localparam logic [4:0]  HB_DST0    = 5'd16;
  localparam logic [4:0]  HB_DST1    = 5'd17;
  localparam logic [4:0]  HB_DST2    = 5'd18;
  localparam logic [4:0]  HB_DST3    = 5'd19;
  localparam logic [4:0]  HB_LAST    = 5'd19;

endpackage

// File: rtl/tx_ip_csum.sv
// ip_hdr_csum: combinational IPv4 header checksum.
// Sums the nine 16-bit header words (checksum field excluded), folds the
// carries twice and inverts.
//   tos, tot_len, id, flags, ttl, protocol, src_addr, dst_addr : header fields
//   csum : checksum to place in header bytes 10/11
module ip_hdr_csum
  import tx_ip_pkg::*;
(
  input  logic [7:0]  tos,
  input  logic [15:0] tot_len,
  input  logic [15:0] id,
  input  logic [2:0]  flags,
  input  logic [7:0]  ttl,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  output logic [15:0] csum
);

  logic [19:0] sum;
  logic [19:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = {4'h0, IP_VER_IHL, tos}
        + {4'h0, tot_len}
        + {4'h0, id}
        + {4'h0, flags, 13'h0}
        + {4'h0, ttl, protocol}
        + {4'h0, src_addr[31:16]}
        + {4'h0, src_addr[15:0]}
        + {4'h0, dst_addr[31:16]}
        + {4'h0, dst_addr[15:0]};
    fold1 = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
    // after the first fold the carry is at most 1 and then the low half is
    // tiny, so the second fold cannot carry out of 16 bits
    fold2 = fold1[15:0] + {12'h0, fold1[19:16]};
    csum  = ~fold2;
  end

endmodule

// File: rtl/tx_ip.sv
// tx_ip: IPv4 transmit header inserter.
// Prepends a 20-byte IPv4 header to a byte-wide AXI-Stream payload.
//   s_axis_aclk, rst            : clock, synchronous active-high reset
//   ip_enable                   : 1 = insert header, 0 = s_* -> m_* bypass
//   IP_DataLen/Protocol/Src/Dest: header fields, sampled at packet start
//   s_axis_*                    : payload in (tuser = first byte)
//   m_axis_*                    : IP packet out (tuser = first header byte)
//   tx_len_err                  : one-cycle pulse on payload length mismatch
//
// state  | meaning
// IDLE   | wait for first payload byte, drop stray bytes
// CSUM   | compute header checksum from latched fields
// HEADER | emit 20 header bytes
// DATA   | pass payload through combinationally
// DRAIN  | discard input up to its tlast
module tx_ip
  import tx_ip_pkg::*;
#(
  parameter logic [7:0]  IP_TTL     = 8'd64,
  parameter logic [2:0]  IP_FLAGS   = 3'b010,
  parameter logic [7:0]  IP_TOS     = 8'd0,
  parameter logic [15:0] IP_ID_INIT = 16'd0
) (
  input  logic        s_axis_aclk,
  input  logic        rst,
  input  logic        ip_enable,
  input  logic [15:0] IP_DataLen,
  input  logic [7:0]  IP_Protocol,
  input  logic [31:0] IP_SrcAddr,
  input  logic [31:0] IP_DestAddr,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        tx_len_err
);

  tx_state_t   state_q, state_d;
  logic [4:0]  hdr_cnt_q;
  logic [15:0] pay_cnt_q, pay_next;
  logic [15:0] data_len_q, tot_len_q, id_q, csum_q, csum_c;
  logic [7:0]  proto_q;
  logic [31:0] src_q, dst_q;
  logic [7:0]  hdr_byte;
  logic        len_err_d;
  logic        id_inc;

  ip_hdr_csum u_csum (
    .tos      (IP_TOS),
    .tot_len  (tot_len_q),
    .id       (id_q),
    .flags    (IP_FLAGS),
    .ttl      (IP_TTL),
    .protocol (proto_q),
    .src_addr (src_q),
    .dst_addr (dst_q),
    .csum     (csum_c)
  );

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt_q)
      HB_VER_IHL: hdr_byte = IP_VER_IHL;
      HB_TOS:     hdr_byte = IP_TOS;
      HB_LEN_HI:  hdr_byte = tot_len_q[15:8];
      HB_LEN_LO:  hdr_byte = tot_len_q[7:0];
      HB_ID_HI:   hdr_byte = id_q[15:8];
      HB_ID_LO:   hdr_byte = id_q[7:0];
      HB_FLAGS:   hdr_byte = {IP_FLAGS, 5'h0};
      HB_FRAG:    hdr_byte = 8'h00;
      HB_TTL:     hdr_byte = IP_TTL;
      HB_PROTO:   hdr_byte = proto_q;
      HB_CS_HI:   hdr_byte = csum_q[15:8];
      HB_CS_LO:   hdr_byte = csum_q[7:0];
      HB_SRC0:    hdr_byte = src_q[31:24];
      HB_SRC1:    hdr_byte = src_q[23:16];
      HB_SRC2:    hdr_byte = src_q[15:8];
      HB_SRC3:    hdr_byte = src_q[7:0];
      HB_DST0:    hdr_byte = dst_q[31:24];
      HB_DST1:    hdr_byte = dst_q[23:16];
      HB_DST2:    hdr_byte = dst_q[15:8];
      HB_DST3:    hdr_byte = dst_q[7:0];
      default:    hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    len_err_d     = 1'b0;
    id_inc        = 1'b0;
    pay_next      = pay_cnt_q + 16'd1;
    if (!ip_enable) begin
      m_axis_tdata  = s_axis_tdata;
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tuser  = s_axis_tuser;
      m_axis_tlast  = s_axis_tlast;
      s_axis_tready = m_axis_tready;
      state_d       = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // the first byte is left pending; anything else is dropped
          s_axis_tready = ~s_axis_tuser;
          if (s_axis_tvalid && s_axis_tuser) state_d = CSUM;
        end
        CSUM: state_d = HEADER;
        HEADER: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = hdr_byte;
          m_axis_tuser  = (hdr_cnt_q == HB_VER_IHL);
          m_axis_tlast  = (hdr_cnt_q == HB_LAST) && (data_len_q == 16'd0);
          if (m_axis_tready && hdr_cnt_q == HB_LAST) begin
            if (data_len_q == 16'd0) begin
              state_d = DRAIN;
              id_inc  = 1'b1;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          m_axis_tdata  = s_axis_tdata;
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          m_axis_tlast  = s_axis_tlast || (pay_next == data_len_q);
          if (s_axis_tvalid && m_axis_tready) begin
            if (s_axis_tlast) begin
              state_d   = IDLE;
              id_inc    = 1'b1;
              len_err_d = (pay_next != data_len_q);
            end else if (pay_next == data_len_q) begin
              state_d   = DRAIN;
              id_inc    = 1'b1;
              len_err_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_cnt_q  <= 5'd0;
      pay_cnt_q  <= 16'd0;
      id_q       <= IP_ID_INIT;
      tx_len_err <= 1'b0;
      data_len_q <= 16'd0;
      tot_len_q  <= 16'd0;
      proto_q    <= 8'h00;
      src_q      <= 32'h0;
      dst_q      <= 32'h0;
      csum_q     <= 16'h0;
    end else begin
      state_q    <= state_d;
      tx_len_err <= len_err_d;
      if (id_inc) id_q <= id_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (ip_enable && s_axis_tvalid && s_axis_tuser) begin
            data_len_q <= IP_DataLen;
            tot_len_q  <= IP_DataLen + 16'd20;
            proto_q    <= IP_Protocol;
            src_q      <= IP_SrcAddr;
            dst_q      <= IP_DestAddr;
          end
        end
        CSUM: begin
          csum_q    <= csum_c;
          hdr_cnt_q <= 5'd0;
        end
        HEADER: begin
          pay_cnt_q <= 16'd0;
          if (m_axis_tready) hdr_cnt_q <= hdr_cnt_q + 5'd1;
        end
        DATA: begin
          if (s_axis_tvalid && m_axis_tready) pay_cnt_q <= pay_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ip.sv
// Directed bench for tx_ip: golden header, back-to-back, backpressure,
// short/long payloads, bypass and mid-header reset.
module tb_tx_ip;

  logic        s_axis_aclk = 1'b0;
  logic        rst;
  logic        ip_enable;
  logic [15:0] IP_DataLen;
  logic [7:0]  IP_Protocol;
  logic [31:0] IP_SrcAddr;
  logic [31:0] IP_DestAddr;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        tx_len_err;

  always #5 s_axis_aclk = ~s_axis_aclk;

  tx_ip dut (
    .s_axis_aclk   (s_axis_aclk),
    .rst           (rst),
    .ip_enable     (ip_enable),
    .IP_DataLen    (IP_DataLen),
    .IP_Protocol   (IP_Protocol),
    .IP_SrcAddr    (IP_SrcAddr),
    .IP_DestAddr   (IP_DestAddr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .tx_len_err    (tx_len_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] in_data [$];
  logic [9:0] out_q [$];   // {tuser, tlast, tdata}
  logic [7:0] exp_hdr [20];
  int         exp_id;
  int         got_err, lat, stall_bad;

  // independent checksum: byte pairs into 32 bits, fold until no carry
  task automatic build_hdr(input int len, input logic [7:0] proto,
                           input logic [31:0] src, input logic [31:0] dst);
    logic [15:0] tot;
    logic [15:0] id;
    int unsigned s;
    logic [15:0] cs;
    tot = 16'(len + 20);
    id  = 16'(exp_id);
    exp_hdr[0]  = 8'h45;  exp_hdr[1]  = 8'h00;
    exp_hdr[2]  = tot[15:8]; exp_hdr[3] = tot[7:0];
    exp_hdr[4]  = id[15:8];  exp_hdr[5] = id[7:0];
    exp_hdr[6]  = 8'h40;  exp_hdr[7]  = 8'h00;
    exp_hdr[8]  = 8'h40;  exp_hdr[9]  = proto;
    exp_hdr[10] = 8'h00;  exp_hdr[11] = 8'h00;
    exp_hdr[12] = src[31:24]; exp_hdr[13] = src[23:16];
    exp_hdr[14] = src[15:8];  exp_hdr[15] = src[7:0];
    exp_hdr[16] = dst[31:24]; exp_hdr[17] = dst[23:16];
    exp_hdr[18] = dst[15:8];  exp_hdr[19] = dst[7:0];
    s = 0;
    for (int i = 0; i < 20; i += 2) s += {16'h0, exp_hdr[i], exp_hdr[i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    exp_hdr[10] = cs[15:8];
    exp_hdr[11] = cs[7:0];
  endtask

  task automatic run_pkt(input string tag, input int len, input int n_in, input int last_at,
                         input bit bp, input int abort_at, input logic [7:0] proto,
                         input logic [31:0] src, input logic [31:0] dst);
    int idx, cyc, quiet, t_start, t_first;
    bit prev_stall;
    logic [9:0] prev_word;
    in_data.delete();
    out_q.delete();
    for (int i = 0; i < n_in; i++) in_data.push_back(8'(i * 37 + len * 5 + 1));
    IP_DataLen  = 16'(len);
    IP_Protocol = proto;
    IP_SrcAddr  = src;
    IP_DestAddr = dst;
    idx = 0; cyc = 0; quiet = 0; t_start = -1; t_first = -1;
    got_err = 0; stall_bad = 0; prev_stall = 0; prev_word = '0;
    while (cyc < 3000) begin
      @(negedge s_axis_aclk);
      if (idx < n_in) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_data[idx];
        s_axis_tuser  = (idx == 0);
        s_axis_tlast  = (idx + 1 == last_at);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (abort_at >= 0 && m_axis_tvalid && out_q.size() == abort_at) begin
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge s_axis_aclk);
        #1;
        check_eq({tag, "_rst_out"},
                 {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, tx_len_err}, 32'h0);
        rst = 1'b0;
        return;
      end
      if (tx_len_err) got_err++;
      if (t_start < 0 && s_axis_tvalid && s_axis_tuser) t_start = cyc;
      if (t_first < 0 && m_axis_tvalid) t_first = cyc;
      if (prev_stall && m_axis_tvalid &&
          {m_axis_tuser, m_axis_tlast, m_axis_tdata} != prev_word) stall_bad++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (s_axis_tvalid && s_axis_tready) idx++;
      if (idx == n_in && !m_axis_tvalid) quiet++; else quiet = 0;
      cyc++;
      if (quiet >= 3) break;
    end
    check_eq({tag, "_timeout"}, 32'(cyc >= 3000), 32'h0);
    lat = t_first - t_start;
  endtask

  task automatic verify(input string tag, input int len, input int last_at);
    int pay_n, exp_n, prev;
    logic [9:0] e;
    pay_n = (last_at >= 1 && last_at <= len) ? last_at : len;
    exp_n = 20 + pay_n;
    check_eq({tag, "_count"}, out_q.size(), exp_n);
    check_eq({tag, "_lenerr"}, got_err, (last_at != len) ? 1 : 0);
    check_eq({tag, "_latency"}, lat, 2);
    check_eq({tag, "_stall"}, stall_bad, 0);
    for (int i = 0; i < exp_n && i < out_q.size(); i++) begin
      if (i < 20) e = {1'(i == 0), 1'(i == 19 && len == 0), exp_hdr[i]};
      else        e = {1'b0, 1'(i == exp_n - 1), in_data[i - 20]};
      prev = n_errors;
      check_eq($sformatf("%s_b%0d", tag, i), out_q[i], e);
      if (n_errors != prev) break;
    end
    exp_id = (exp_id + 1) & 16'hFFFF;
  endtask

  logic [7:0] golden [20];

  initial begin
    golden = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    rst = 1'b1; ip_enable = 1'b1;
    IP_DataLen = '0; IP_Protocol = '0; IP_SrcAddr = '0; IP_DestAddr = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    exp_id = 0;
    repeat (3) @(negedge s_axis_aclk);
    #1;
    check_eq("reset_out", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, tx_len_err}, 32'h0);
    rst = 1'b0;

    // golden header
    build_hdr(95, 8'h11, 32'hC0A80001, 32'hC0A800C7);
    run_pkt("gold", 95, 95, 95, 0, -1, 8'h11, 32'hC0A80001, 32'hC0A800C7);
    for (int i = 0; i < 20 && i < out_q.size(); i++)
      check_eq($sformatf("gold_hdr%0d", i), out_q[i][7:0], golden[i]);
    verify("gold", 95, 95);

    // back-to-back
    build_hdr(8, 8'h11, 32'h0A000001, 32'h0A000002);
    run_pkt("b2b_a", 8, 8, 8, 0, -1, 8'h11, 32'h0A000001, 32'h0A000002);
    verify("b2b_a", 8, 8);
    build_hdr(8, 8'h11, 32'h0A000001, 32'h0A000002);
    run_pkt("b2b_b", 8, 8, 8, 0, -1, 8'h11, 32'h0A000001, 32'h0A000002);
    verify("b2b_b", 8, 8);

    // backpressure
    build_hdr(12, 8'h06, 32'h12345678, 32'h9ABCDEF0);
    run_pkt("bp", 12, 12, 12, 1, -1, 8'h06, 32'h12345678, 32'h9ABCDEF0);
    verify("bp", 12, 12);

    // short payload, then a clean packet
    build_hdr(10, 8'h11, 32'hAC100001, 32'hAC1000FE);
    run_pkt("short", 10, 6, 6, 1, -1, 8'h11, 32'hAC100001, 32'hAC1000FE);
    verify("short", 10, 6);
    build_hdr(5, 8'h01, 32'hFFFFFFFF, 32'h00000000);
    run_pkt("after_short", 5, 5, 5, 0, -1, 8'h01, 32'hFFFFFFFF, 32'h00000000);
    verify("after_short", 5, 5);

    // long payload: forced tlast on byte 4, bytes 5..7 drained
    build_hdr(4, 8'h11, 32'h01020304, 32'h05060708);
    run_pkt("long", 4, 7, 7, 0, -1, 8'h11, 32'h01020304, 32'h05060708);
    verify("long", 4, 7);

    // bypass
    ip_enable = 1'b0;
    for (int v = 0; v < 4; v++) begin
      @(negedge s_axis_aclk);
      s_axis_tdata  = 8'(8'h5A + v * 8'h33);
      s_axis_tvalid = 1'(v != 2);
      s_axis_tuser  = 1'(v == 0);
      s_axis_tlast  = 1'(v == 3);
      m_axis_tready = 1'(v[0]);
      #1;
      check_eq($sformatf("bypass%0d", v),
               {m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready},
               {8'(8'h5A + v * 8'h33), 1'(v != 2), 1'(v == 0), 1'(v == 3), 1'(v[0])});
    end
    @(negedge s_axis_aclk);
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    ip_enable = 1'b1;
    @(negedge s_axis_aclk);

    // reset while header byte 7 is presented; ID restarts at 0
    build_hdr(9, 8'h11, 32'h0B0B0B0B, 32'h0C0C0C0C);
    run_pkt("rst_mid", 9, 9, 9, 0, 7, 8'h11, 32'h0B0B0B0B, 32'h0C0C0C0C);
    exp_id = 0;
    @(negedge s_axis_aclk);
    build_hdr(3, 8'h11, 32'h0B0B0B0B, 32'h0C0C0C0C);
    run_pkt("post_rst", 3, 3, 3, 0, -1, 8'h11, 32'h0B0B0B0B, 32'h0C0C0C0C);
    verify("post_rst", 3, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
